// File: rtl/uart_loader.sv
// Boot loader: assembles a little-endian word count and instruction words from the
// UART byte stream, writes them to instruction memory from address 0, then sends an ack byte.
module uart_loader #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_ferr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN, DATA, ACK, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   loaded_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d;
  logic                  tx_start_d;
  logic                  busy_d, done_d, err_d;
  logic [31:0]           assembled;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  accept, ferr_hit;

  assign accept     = rx_valid & ~rx_ferr;
  assign ferr_hit   = rx_valid & rx_ferr;
  assign next_count = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      len_q        <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      tx_start     <= 1'b0;
      tx_data      <= ACK_BYTE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      len_q        <= len_d;
      words_loaded <= loaded_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      tx_start     <= tx_start_d;
      tx_data      <= ACK_BYTE;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    len_d       = len_q;
    loaded_d    = words_loaded;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    tx_start_d  = 1'b0;
    assembled   = word_q;
    assembled[{byte_cnt_q, 3'b000} +: 8] = rx_data;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          byte_cnt_d = 2'd0;
          word_d     = 32'd0;
          loaded_d   = '0;
        end
      end
      LEN: begin
        if (ferr_hit) begin
          state_d = ERR;
        end else if (accept) begin
          word_d     = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (assembled == 32'd0) begin
              state_d = ACK;
            end else if ({1'b0, assembled} > MAX_WORDS) begin
              state_d = ERR;
            end else begin
              len_d   = assembled[ADDR_WIDTH:0];
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (ferr_hit) begin
          state_d = ERR;
        end else if (accept) begin
          word_d     = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // The 2-bit counter wraps to 0 on the 4th byte, ready for the next word.
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = words_loaded[ADDR_WIDTH-1:0];
            mem_wdata_d = assembled;
            loaded_d    = next_count;
            if (next_count == len_q) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LEN) || (state_d == DATA) || (state_d == ACK);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader (ADDR_WIDTH=4): stimulus queues expected writes and
// ack bytes, a negedge monitor pops and compares them whenever the DUT emits one.
module tb_uart_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ferr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          busy, done, err;
  logic [AW:0]   words_loaded;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  int         tx_count = 0;
  logic       prev_we = 1'b0;
  logic       busy_at_edge = 1'b0;

  uart_loader #(.ADDR_WIDTH(AW), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event seen, none expected", name);
  endtask

  always @(posedge clk) busy_at_edge <= tx_busy;

  // Monitor: every write and every ack request must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (prev_we) report_fail("mem_we_consecutive");
        if (exp_wr.size() == 0) report_fail("unexpected_mem_we");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          checkOutput("mem_addr", 64'(mem_addr), 64'(e.addr));
          checkOutput("mem_wdata", 64'(mem_wdata), 64'(e.data));
        end
      end
      prev_we = mem_we;
      if (tx_start) begin
        tx_count++;
        checkOutput("tx_busy_at_start", 64'(busy_at_edge), 64'd0);
        if (exp_tx.size() == 0) report_fail("unexpected_tx_start");
        else checkOutput("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic ferr);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_ferr = ferr;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], 1'b0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic expect_write(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    exp_wr.push_back(e);
  endtask

  task automatic wait_end(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done/err expected done or err", name);
    end
    @(negedge clk);
  endtask

  task automatic check_queues(input string name);
    checkOutput({name, "_wr_pending"}, 64'(exp_wr.size()), 64'd0);
    checkOutput({name, "_tx_pending"}, 64'(exp_tx.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string name);
    checkOutput({name, "_mem_we"}, 64'(mem_we), 64'd0);
    checkOutput({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({name, "_tx_start"}, 64'(tx_start), 64'd0);
    checkOutput({name, "_tx_data"}, 64'(tx_data), 64'hAA);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_done"}, 64'(done), 64'd0);
    checkOutput({name, "_err"}, 64'(err), 64'd0);
    checkOutput({name, "_words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    int tc;
    #23 check_reset_values("reset");
    rst = 1'b0;

    // Normal two-word load
    expect_write(0, 32'h12345678);
    expect_write(1, 32'hDEADBEEF);
    exp_tx.push_back(8'hAA);
    pulse_start();
    checkOutput("normal_busy", 64'(busy), 64'd1);
    send_word(32'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    wait_end("normal");
    checkOutput("normal_done", 64'(done), 64'd1);
    checkOutput("normal_err", 64'(err), 64'd0);
    checkOutput("normal_words", 64'(words_loaded), 64'd2);
    checkOutput("normal_busy_end", 64'(busy), 64'd0);
    check_queues("normal");

    // Zero length
    exp_tx.push_back(8'hAA);
    pulse_start();
    checkOutput("zero_done_cleared", 64'(done), 64'd0);
    send_word(32'd0);
    wait_end("zero");
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_words", 64'(words_loaded), 64'd0);
    check_queues("zero");

    // Oversize length 17
    tc = tx_count;
    pulse_start();
    send_word(32'h11);
    wait_end("oversize");
    checkOutput("oversize_err", 64'(err), 64'd1);
    checkOutput("oversize_done", 64'(done), 64'd0);
    checkOutput("oversize_no_tx", 64'(tx_count), 64'(tc));
    check_queues("oversize");

    // Maximum length 16
    for (int i = 0; i < 16; i++) expect_write(i, 32'hA5000000 + 32'(i * 3));
    exp_tx.push_back(8'hAA);
    pulse_start();
    send_word(32'h10);
    for (int i = 0; i < 16; i++) send_word(32'hA5000000 + 32'(i * 3));
    wait_end("max");
    checkOutput("max_done", 64'(done), 64'd1);
    checkOutput("max_words", 64'(words_loaded), 64'd16);
    check_queues("max");

    // Framing error on byte 2 of word 1, then a clean reload
    expect_write(0, 32'h04030201);
    pulse_start();
    send_word(32'd2);
    send_word(32'h04030201);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b0);
    wait_end("ferr");
    checkOutput("ferr_err", 64'(err), 64'd1);
    checkOutput("ferr_done", 64'(done), 64'd0);
    checkOutput("ferr_words", 64'(words_loaded), 64'd1);
    check_queues("ferr");
    expect_write(0, 32'hCAFEF00D);
    exp_tx.push_back(8'hAA);
    pulse_start();
    checkOutput("reload_err_cleared", 64'(err), 64'd0);
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    wait_end("reload");
    checkOutput("reload_done", 64'(done), 64'd1);
    checkOutput("reload_words", 64'(words_loaded), 64'd1);
    check_queues("reload");

    // Transmitter backpressure for 50 cycles
    tx_busy = 1'b1;
    expect_write(0, 32'h0BADF00D);
    exp_tx.push_back(8'hAA);
    pulse_start();
    send_word(32'd1);
    send_word(32'h0BADF00D);
    tc = tx_count;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("bp_no_tx", 64'(tx_count), 64'(tc));
    checkOutput("bp_busy", 64'(busy), 64'd1);
    checkOutput("bp_done", 64'(done), 64'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("bp_tx_not_yet", 64'(tx_start), 64'd0);
    @(negedge clk);
    checkOutput("bp_tx_start", 64'(tx_start), 64'd1);
    @(negedge clk);
    checkOutput("bp_tx_single", 64'(tx_start), 64'd0);
    checkOutput("bp_done_after", 64'(done), 64'd1);
    check_queues("bp");

    // Reset between bytes of word 0
    pulse_start();
    send_word(32'd1);
    applyStimulus(8'hAB, 1'b0);
    applyStimulus(8'hCD, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clk); #1 rst = 1'b0;
    applyStimulus(8'hEF, 1'b0);
    applyStimulus(8'h01, 1'b0);
    repeat (5) @(negedge clk);
    check_reset_values("after_reset");

    // start pulsed during DATA is ignored
    expect_write(0, 32'h44332211);
    expect_write(1, 32'h88776655);
    exp_tx.push_back(8'hAA);
    pulse_start();
    send_word(32'd2);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    pulse_start();
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b0);
    checkOutput("ign_start_words", 64'(words_loaded), 64'd1);
    send_word(32'h88776655);
    wait_end("ign_start");
    checkOutput("ign_start_done", 64'(done), 64'd1);
    checkOutput("ign_start_total", 64'(words_loaded), 64'd2);
    check_queues("ign_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
